// File: rtl/alu_issue_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_unit_if
// Description : Command, result and ALU-side signal bundle for alu_issue_unit
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_unit_if #(
    parameter int DEPTH = 4
) ();
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_a;
    logic [3:0]         in_b;
    logic [2:0]         in_s;
    logic               in_acc;
    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic [2:0]         alu_s;
    logic [3:0]         alu_o;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_data;
    logic [2:0]         out_s;
    logic [c_cnt_w-1:0] count;

    modport master (
        output in_valid, in_a, in_b, in_s, in_acc, out_ready, alu_o,
        input  in_ready, alu_a, alu_b, alu_s, out_valid, out_data, out_s, count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_s, in_acc, out_ready, alu_o,
        output in_ready, alu_a, alu_b, alu_s, out_valid, out_data, out_s, count
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_unit
// Description : Command FIFO, issue logic, result slot and accumulator
//               wrapped around an external 4-bit combinational ALU
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_unit #(
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_issue_unit_if.slave bus
);
    localparam int                c_addr_w = $clog2(DEPTH);
    localparam int                c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] s;
        logic       acc;
    } cmd_t;

    cmd_t                mem_q [DEPTH];
    logic [c_addr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_addr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic [3:0]          acc_q, acc_d;
    logic [3:0]          out_data_q, out_data_d;
    logic [2:0]          out_s_q, out_s_d;
    logic                out_valid_q, out_valid_d;

    cmd_t                w_head;
    cmd_t                w_cmd_in;
    logic                w_empty;
    logic                w_in_ready;
    logic                w_push;
    logic                w_issue;
    logic [3:0]          w_alu_a;
    logic [3:0]          w_alu_b;
    logic [2:0]          w_alu_s;

    // in_ready is a pure function of occupancy so no path exists from out_ready
    assign w_in_ready = (count_q < c_full);
    assign w_empty    = (count_q == '0);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_issue    = !w_empty && (!out_valid_q || bus.out_ready);
    assign w_head     = mem_q[rd_ptr_q];
    assign w_cmd_in   = '{a: bus.in_a, b: bus.in_b, s: bus.in_s, acc: bus.in_acc};

    always_comb begin
        w_alu_a = '0;
        w_alu_b = '0;
        w_alu_s = '0;
        if (!w_empty) begin
            w_alu_a = w_head.acc ? acc_q : w_head.a;
            w_alu_b = w_head.b;
            w_alu_s = w_head.s;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_s_d     = out_s_q;
        out_valid_d = out_valid_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_addr_w'(1);
        end

        if (w_issue) begin
            out_data_d  = bus.alu_o;
            out_s_d     = w_alu_s;
            out_valid_d = 1'b1;
            acc_d       = bus.alu_o;
            rd_ptr_d    = rd_ptr_q + c_addr_w'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case ({w_push, w_issue})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_s_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_s_q     <= out_s_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= w_cmd_in;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.alu_a     = w_alu_a;
    assign bus.alu_b     = w_alu_b;
    assign bus.alu_s     = w_alu_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_s     = out_s_q;
    assign bus.count     = count_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_unit
// Description : Scoreboard bench for alu_issue_unit with a behavioural ALU
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_unit;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [3:0] model_acc;
    logic [6:0] exp_q [$];

    alu_issue_unit_if #(.DEPTH(DEPTH)) bus ();

    alu_issue_unit #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] s);
        case (s)
            3'b000:  return a | b;
            3'b001:  return a & b;
            3'b010:  return a + b;
            3'b011:  return a - b;
            default: return (a < b) ? a : b;
        endcase
    endfunction

    assign bus.alu_o = alu_ref(bus.alu_a, bus.alu_b, bus.alu_s);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

    // Each result handshake that completes on the next rising edge is checked here
    always @(negedge clk) begin : monitor
        logic [6:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_extra: got s=%b data=%h, required no result", bus.out_s, bus.out_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.out_s, bus.out_data} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_result: got s=%b data=%h, required s=%b data=%h",
                             bus.out_s, bus.out_data, e[6:4], e[3:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                            input logic acc);
        int n;
        logic [3:0] r;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_s     = s;
        bus.in_acc   = acc;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0, required 1 within 100 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        r = alu_ref(acc ? model_acc : a, b, s);
        model_acc = r;
        exp_q.push_back({s, r});
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0 || bus.out_valid) begin
            n_fail++;
            $display("FAIL %s_drain: pending=%0d out_valid=%b, required pending=0 out_valid=0",
                     name, exp_q.size(), bus.out_valid);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        n_checks++;
        if ({bus.count, bus.out_valid, bus.out_data, bus.out_s} !== '0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d out_valid=%b data=%h s=%b in_ready=%b, required 0,0,0,0,1",
                     bus.count, bus.out_valid, bus.out_data, bus.out_s, bus.in_ready);
        end
        n_checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_s} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_alu: alu_a=%h alu_b=%h alu_s=%b, required all 0", bus.alu_a, bus.alu_b, bus.alu_s);
        end
        model_acc = 4'h0;
    endtask

    task automatic test_single();
        bus.out_ready = 1'b0;
        push_cmd(4'd5, 4'd3, 3'b010, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_pushed: out_valid=%b count=%0d, required 0 and 1", bus.out_valid, bus.count);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd8 || bus.out_s !== 3'b010 || bus.count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_result: valid=%b data=%h s=%b count=%0d, required 1,8,010,0",
                     bus.out_valid, bus.out_data, bus.out_s, bus.count);
        end
        wait_drain("single");
    endtask

    task automatic test_chain();
        bus.out_ready = 1'b1;
        push_cmd(4'd5, 4'd3, 3'b010, 1'b0);
        push_cmd(4'hF, 4'd2, 3'b011, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd8) begin
            n_fail++;
            $display("FAIL chain_first: valid=%b data=%h, required 1 and 8", bus.out_valid, bus.out_data);
        end
        push_cmd(4'hF, 4'd4, 3'b100, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd6) begin
            n_fail++;
            $display("FAIL chain_second: valid=%b data=%h, required 1 and 6", bus.out_valid, bus.out_data);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd4 || bus.out_s !== 3'b100) begin
            n_fail++;
            $display("FAIL chain_third: valid=%b data=%h s=%b, required 1,4,100", bus.out_valid, bus.out_data, bus.out_s);
        end
        wait_drain("chain");
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        push_cmd(4'hC, 4'h3, 3'b000, 1'b0);
        push_cmd(4'hC, 4'h6, 3'b001, 1'b0);
        push_cmd(4'h9, 4'h9, 3'b010, 1'b0);
        push_cmd(4'h2, 4'h5, 3'b011, 1'b0);
        push_cmd(4'h9, 4'h4, 3'b111, 1'b0);
        n_checks++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0 || bus.out_data !== 4'hF || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_state: count=%0d in_ready=%b data=%h valid=%b, required 4,0,F,1",
                     bus.count, bus.in_ready, bus.out_data, bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.in_a = 4'h1; bus.in_b = 4'h1; bus.in_s = 3'b010; bus.in_acc = 1'b0;
        repeat (3) step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_held: count=%0d in_ready=%b, required 4 and 0", bus.count, bus.in_ready);
        end
        wait_drain("full");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            bus.out_ready = (i % 2 == 0);
            push_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (bus.count > 3'd4) begin
                n_fail++;
                $display("FAIL wrap_count: count=%0d, required <= 4", bus.count);
            end
        end
        wait_drain("wrap");
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        push_cmd(4'h6, 4'h3, 3'b011, 1'b0);
        push_cmd(4'h1, 4'h2, 3'b000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) push_cmd(4'hF, 4'h1, 3'b010, 1'b1);
            else step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h3 || bus.out_s !== 3'b011 ||
                bus.count !== 3'((k < 3) ? k + 2 : 4)) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid=%b data=%h s=%b count=%0d, required 1,3,011,%0d",
                         k, bus.out_valid, bus.out_data, bus.out_s, bus.count, (k < 3) ? k + 2 : 4);
            end
        end
        wait_drain("stall");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        push_cmd(4'h1, 4'h2, 3'b010, 1'b0);
        push_cmd(4'h3, 4'h4, 3'b010, 1'b0);
        push_cmd(4'h5, 4'h6, 3'b010, 1'b0);
        push_cmd(4'h7, 4'h8, 3'b010, 1'b0);
        n_checks++;
        if (bus.count !== 3'd3 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: count=%0d valid=%b, required 3 and 1", bus.count, bus.out_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        model_acc = 4'h0;
        n_checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || {bus.alu_a, bus.alu_b, bus.alu_s} !== 11'd0) begin
            n_fail++;
            $display("FAIL rstmid_state: count=%0d valid=%b alu_a=%h alu_b=%h alu_s=%b, required all 0",
                     bus.count, bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_s);
        end
        bus.out_ready = 1'b1;
        push_cmd(4'hF, 4'h7, 3'b010, 1'b1);
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h7) begin
            n_fail++;
            $display("FAIL rstmid_chain: valid=%b data=%h, required 1 and 7", bus.out_valid, bus.out_data);
        end
        wait_drain("rstmid");
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        model_acc     = 4'h0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_s      = '0;
        bus.in_acc    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_chain();
        test_full();
        test_wrap();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_issue_unit.md
# alu_issue_unit

Command queue and result stage wrapped around the 4-bit combinational ALU (opcode `s`: 000 OR, 001 AND, 010 ADD, 011 SUB, others MIN).
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues one command per cycle to the ALU.
- Registers each ALU result into an output slot with its own valid/ready handshake.
- Keeps an accumulator of the last result, so commands can chain on the previous result instead of a supplied operand.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  command present
- in_ready  out  1  queue can accept; equals count < DEPTH
- in_a  in  4  operand A
- in_b  in  4  operand B
- in_s  in  3  ALU opcode
- in_acc  in  1  1 = use accumulator in place of in_a
- alu_a  out  4  operand A to ALU
- alu_b  out  4  operand B to ALU
- alu_s  out  3  opcode to ALU
- alu_o  in  4  combinational ALU result
- out_valid  out  1  result slot full
- out_ready  in  1  downstream takes result
- out_data  out  4  registered result
- out_s  out  3  opcode that produced out_data
- count  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- Reset (rst=1 at an edge) clears the following to 0: wr_ptr, rd_ptr, count, acc, out_valid, out_data, out_s.
  - Reset overrides every push, issue and pop in that cycle.
  - Commands still in the FIFO or held in the output slot are discarded.
- Push: in_valid && in_ready at an edge writes {in_a, in_b, in_s, in_acc} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Head drive, combinational from the rd_ptr entry:
  - alu_a = head.acc ? acc : head.a
  - alu_b = head.b
  - alu_s = head.s
  - When count == 0, alu_a, alu_b and alu_s are driven to 0.
- Issue condition: count > 0 && (!out_valid || out_ready). On issue:
  - out_data <= alu_o, out_s <= alu_s, out_valid <= 1
  - acc <= alu_o
  - rd_ptr advances, wrapping modulo DEPTH.
- Pop without issue: out_valid && out_ready && count == 0 sets out_valid <= 0.
- Output stall: out_valid && !out_ready holds out_data and out_s stable; no issue occurs.
- count: +1 on push only, -1 on issue only, unchanged on simultaneous push and issue.
- Arithmetic: all values are 4-bit; overflow and borrow wrap inside the ALU. This block adds no carry or flags.

## Timing
- in_ready depends only on count; there is no combinational path from out_ready or in_valid.
  - At count == DEPTH, in_ready = 0 even if an issue happens in the same cycle.
- Latency: a command pushed at edge E into an empty queue with an empty or draining output slot appears as out_valid = 1 after edge E+1.
- Throughput: one command per cycle sustained when out_ready is held at 1.
- Chaining: a chained command issued at edge E+1 directly after the command issued at edge E uses the acc value written at edge E. Back-to-back chained commands need no bubble.
- Simultaneous push into an empty queue and issue: none. The new entry becomes head the next cycle, because push and issue do not bypass each other.
- Full and pointer wrap: after DEPTH pushes with no issue, count = DEPTH and wr_ptr == rd_ptr; the next push and issue are correct after wrap.

## Test plan
- Reset then a single op: push a=5, b=3, s=010 → out_valid rises one edge after the push; out_data=8, out_s=010; acc=8; count returns to 0.
- Chaining: push {5, 3, 010}, then {x, 2, 011, acc=1}, then {x, 4, 100, acc=1} on back-to-back cycles with out_ready=1 → outputs 8, 6, 4 on consecutive cycles.
- Full and backpressure: out_ready=0, push 5 commands with DEPTH=4.
  - First result lands in the output slot; then count reaches 4 and in_ready=0.
  - 5th command is held.
  - Raising out_ready drains all 5 in order: OR 0xC|0x3=F, AND 0xC&0x6=4, ADD 9+9=2, SUB 2-5=D, MIN(9,4)=4.
- Wrap-around: run 10 push/issue pairs through DEPTH=4 with out_ready toggling 1,0,1,0 → no loss, no duplication, results in order; count never exceeds 4.
- Reset mid-operation: with count=3 and out_valid=1, assert rst for one cycle → next cycle count=0, out_valid=0, acc=0, alu_* = 0. A following chained op {x, 7, 010, acc=1} yields 7.
- Stall stability: out_valid=1 with out_ready=0 for 5 cycles while pushing → out_data and out_s unchanged; acc unchanged; count increments only.
